// File: rtl/mem_lsu.sv
// Load/store unit between a CPU request/response port and a single-cycle registered RAM.
// Handles byte/half/word accesses with lane alignment, sign/zero extension and error checks.
module mem_lsu #(
  parameter int unsigned ADDRESS_WIDTH = 10,
  parameter int unsigned BYTES         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BYTES-1:0]         mem_be,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [1:0]               off_q, off_d;
  logic                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]         be_q, be_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;

  logic                     accept;
  logic                     req_err;
  logic [31:0]              addr_hi;
  logic [BYTES-1:0]         be_calc;
  logic [31:0]              wdata_calc;
  logic [31:0]              rd_shift;
  logic [31:0]              rd_ext;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  // Any address bit above the RAM's reach makes the request out of range.
  assign addr_hi   = req_addr >> (ADDRESS_WIDTH + 2);

  // Decode size/offset into lane enables, replicated write data and error flag.
  always_comb begin
    be_calc    = '0;
    wdata_calc = req_wdata;
    req_err    = 1'b0;
    case (req_size)
      2'd0: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_calc    = 4'b0011 << req_addr[1:0];
        wdata_calc = {2{req_wdata[15:0]}};
        req_err    = req_addr[0];
      end
      2'd2: begin
        be_calc = 4'b1111;
        req_err = |req_addr[1:0];
      end
      default: req_err = 1'b1;
    endcase
    if (addr_hi != '0) req_err = 1'b1;
  end

  // Move the addressed lane down to bit 0, then extend to the access size.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rd_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          rdata_d = '0;
          err_d   = req_err;
          if (req_err) begin
            state_d = StResp;
          end else begin
            mem_addr_d = req_addr[ADDRESS_WIDTH+1:2];
            be_d       = be_calc;
            wdata_d    = wdata_calc;
            state_d    = StIssue;
          end
        end
      end
      StIssue: state_d = we_q ? StResp : StWait;
      StWait: begin
        rdata_d = rd_ext;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= 2'd0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM strobes derive from the state register so reset kills them without waiting for a clock.
  assign mem_we     = (state_q == StIssue) & we_q;
  assign mem_be     = (state_q == StIssue) ? be_q : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state_q == StResp);
  assign resp_err   = (state_q == StResp) & err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural registered-read RAM and hand-computed results.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_lsu #(.ADDRESS_WIDTH(10), .BYTES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request/response; reports latency (cycles after acceptance) and observed RAM strobes.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int we_cyc, output logic [3:0] be_seen,
                          output logic [31:0] wd_seen);
    lat = 0; we_cyc = 0; be_seen = '0; wd_seen = '0;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      if (mem_be != '0) begin be_seen = mem_be; wd_seen = mem_wdata; end
      if (mem_we) we_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) lat = -1;
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", {31'd0, resp_valid}, 32'd0);
  endtask

  int          lat, we_cyc;
  logic [31:0] rdata, wd_seen;
  logic        err;
  logic [3:0]  be_seen;

  initial begin
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    #1 check("rst_ready_first", {31'd0, req_ready}, 32'd1);

    // Preload RAM[5] through a word store.
    transact(1'b1, 32'h14, 2'd2, 1'b0, 32'h8899AABB, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("sw_lat", lat, 2);
    check("sw_be", {28'd0, be_seen}, 32'hF);
    check("sw_wdata", wd_seen, 32'h8899AABB);
    check("sw_we_cyc", we_cyc, 1);

    transact(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lw_data", rdata, 32'h8899AABB);
    check("lw_lat", lat, 3);
    check("lw_err", {31'd0, err}, 32'd0);
    check("lw_we_cyc", we_cyc, 0);

    transact(1'b0, 32'h17, 2'd0, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lb_signed", rdata, 32'hFFFFFF88);
    transact(1'b0, 32'h17, 2'd0, 1'b1, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lbu", rdata, 32'h00000088);
    transact(1'b0, 32'h14, 2'd0, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lb_lane0", rdata, 32'hFFFFFFBB);
    transact(1'b0, 32'h16, 2'd1, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lh_signed", rdata, 32'hFFFF8899);
    transact(1'b0, 32'h14, 2'd1, 1'b1, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lhu", rdata, 32'h0000AABB);

    transact(1'b1, 32'h16, 2'd1, 1'b0, 32'h00001234, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("sh_be", {28'd0, be_seen}, 32'hC);
    check("sh_wdata", wd_seen, 32'h12341234);
    check("sh_we_cyc", we_cyc, 1);
    check("sh_lat", lat, 2);
    check("sh_rdata", rdata, 32'd0);
    transact(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lw_after_sh", rdata, 32'h1234AABB);

    transact(1'b1, 32'h15, 2'd0, 1'b0, 32'h000000CD, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("sb_be", {28'd0, be_seen}, 32'h2);
    check("sb_wdata", wd_seen, 32'hCDCDCDCD);
    transact(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("lw_after_sb", rdata, 32'h1234CDBB);

    // Error cases: misaligned half, misaligned word, illegal size, out of range.
    transact(1'b1, 32'h13, 2'd1, 1'b0, 32'hFFFF, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("err_half_err", {31'd0, err}, 32'd1);
    check("err_half_lat", lat, 1);
    check("err_half_we", we_cyc, 0);
    check("err_half_be", {28'd0, be_seen}, 32'd0);
    transact(1'b0, 32'h22, 2'd2, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("err_word_err", {31'd0, err}, 32'd1);
    check("err_word_rdata", rdata, 32'd0);
    check("err_word_lat", lat, 1);
    transact(1'b1, 32'h14, 2'd3, 1'b0, 32'h0, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("err_size_err", {31'd0, err}, 32'd1);
    check("err_size_we", we_cyc, 0);
    transact(1'b1, 32'h1000, 2'd2, 1'b0, 32'h5555AAAA, lat, rdata, err, we_cyc, be_seen, wd_seen);
    check("err_range_err", {31'd0, err}, 32'd1);
    check("err_range_lat", lat, 1);
    check("err_range_we", we_cyc, 0);
    check("ram_after_err", ram[5], 32'h1234CDBB);

    // Backpressure: hold resp_ready low for 5 cycles on a load.
    begin
      logic stable;
      int   n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_size = 2'd2; req_unsigned = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 8) begin @(negedge clk); n++; end
      check("bp_lat", n, 3);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (!resp_valid || resp_rdata !== 32'h1234CDBB || resp_err !== 1'b0 || req_ready)
          stable = 1'b0;
        @(negedge clk);
      end
      check("bp_stable", {31'd0, stable}, 32'd1);
      check("bp_still_valid", {31'd0, resp_valid}, 32'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("bp_drop", {31'd0, resp_valid}, 32'd0);
      check("bp_ready_back", {31'd0, req_ready}, 32'd1);
    end

    // Reset during store ISSUE.
    begin
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_size = 2'd2;
      req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_issue_we_pre", {31'd0, mem_we}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_issue_we", {31'd0, mem_we}, 32'd0);
      check("rst_issue_be", {28'd0, mem_be}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
        if (resp_valid) seen++;
        @(negedge clk);
      end
      check("rst_no_resp", seen, 0);
      check("rst_ram_kept", ram[5], 32'h1234CDBB);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
